morse_sequencer: RTL and testbench

Sequences the Morse output pin from buffered characters. It accepts one pre-encoded character at a time from the character buffer over a valid/ready handshake. It then drives the key line with standard ITU timing: dot 1 unit, dash 3, symbol gap 1, character gap 3, word gap 7. It sits between the PS/2-fed buffer/encoder stage and `uo_out[0]`, and owns all on/off timing of the key line.

---
 rtl/morse_sequencer_if.sv | 34 +++
 rtl/morse_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_morse_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/morse_sequencer_if.sv
// Character handshake and key-line bundle between the buffer/encoder stage
// and the Morse sequencer. The upstream side drives the character fields;
// the sequencer returns ready, busy and the key line.
interface morse_sequencer_if;
  logic       char_valid;
  logic [2:0] char_len;
  logic [5:0] char_pattern;
  logic       char_space;
  logic       char_ready;
  logic       morse_out;
  logic       busy;

  // Upstream (character buffer / encoder) view
  modport master (
    output char_valid,
    output char_len,
    output char_pattern,
    output char_space,
    input  char_ready,
    input  morse_out,
    input  busy
  );

  // Sequencer view
  modport slave (
    input  char_valid,
    input  char_len,
    input  char_pattern,
    input  char_space,
    output char_ready,
    output morse_out,
    output busy
  );
endinterface

// File: rtl/morse_sequencer.sv
// Morse key-line sequencer.
// Accepts one pre-encoded character (or a word-space request) per handshake
// and plays it out on the key line with ITU timing: dot 1 unit, dash 3,
// symbol gap 1, character gap 3. A word space adds 4 units on top of the
// character gap that already followed the previous character, giving 7.
// All outputs are registered; nothing combinational reaches a port.
module morse_sequencer #(
  parameter logic [23:0] UNIT_COUNT = 24'd10_000_000
) (
  input  logic              clk,
  input  logic              rst,
  morse_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MARK     = 3'd1,
    ST_SYM_GAP  = 3'd2,
    ST_CHAR_GAP = 3'd3,
    ST_WORD_GAP = 3'd4
  } state_t;

  // Unit counts for each timed state
  localparam logic [2:0] UNITS_DOT      = 3'd1;
  localparam logic [2:0] UNITS_DASH     = 3'd3;
  localparam logic [2:0] UNITS_SYM_GAP  = 3'd1;
  localparam logic [2:0] UNITS_CHAR_GAP = 3'd3;
  localparam logic [2:0] UNITS_WORD_GAP = 3'd4;
  localparam logic [23:0] LAST_COUNT    = UNIT_COUNT - 24'd1;

  state_t      state_q, state_d;
  logic [23:0] cyc_q, cyc_d;       // cycles elapsed inside the current unit
  logic [2:0]  units_q, units_d;   // units remaining in the current state
  logic [2:0]  idx_q, idx_d;       // index of the symbol being keyed
  logic [5:0]  pat_q, pat_d;       // latched symbol pattern
  logic        morse_q, morse_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;

  logic        xfer_s;
  logic [2:0]  clen_s;
  logic [2:0]  first_idx_s;
  logic [2:0]  next_idx_s;
  logic        tick_s;
  logic        unit_done_s;

  // Duration of a mark for the symbol at position idx of pat.
  // Out-of-range indices cannot occur; they decode as a dot.
  function automatic logic [2:0] mark_units(input logic [5:0] pat,
                                            input logic [2:0] idx);
    logic dash;
    case (idx)
      3'd0:    dash = pat[0];
      3'd1:    dash = pat[1];
      3'd2:    dash = pat[2];
      3'd3:    dash = pat[3];
      3'd4:    dash = pat[4];
      3'd5:    dash = pat[5];
      default: dash = 1'b0;
    endcase
    return dash ? UNITS_DASH : UNITS_DOT;
  endfunction

  // Handshake decode, length clamp and unit-timer terminal count
  always_comb begin
    xfer_s      = bus.char_valid & ready_q;
    clen_s      = (bus.char_len == 3'd7) ? 3'd6 : bus.char_len;
    first_idx_s = clen_s - 3'd1;
    next_idx_s  = idx_q - 3'd1;
    tick_s      = (cyc_q == LAST_COUNT);
    unit_done_s = (state_q != ST_IDLE) && tick_s && (units_q == 3'd1);
  end

  // Next-state logic: sequencing, counter reloads and output decode
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    units_d = units_q;
    idx_d   = idx_q;
    pat_d   = pat_q;

    if (state_q == ST_IDLE) begin
      // Counters rest at zero while idle
      cyc_d   = 24'd0;
      units_d = 3'd0;
    end else if (tick_s) begin
      cyc_d   = 24'd0;
      units_d = units_q - 3'd1;
    end else begin
      cyc_d   = cyc_q + 24'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (xfer_s) begin
          pat_d = bus.char_pattern;
          if (bus.char_space) begin
            state_d = ST_WORD_GAP;
            units_d = UNITS_WORD_GAP;
          end else if (clen_s == 3'd0) begin
            // Empty character: consumed, nothing keyed
            state_d = ST_IDLE;
            units_d = 3'd0;
          end else begin
            state_d = ST_MARK;
            idx_d   = first_idx_s;
            units_d = mark_units(bus.char_pattern, first_idx_s);
          end
          cyc_d = 24'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_MARK: begin
        if (unit_done_s) begin
          cyc_d = 24'd0;
          if (idx_q != 3'd0) begin
            state_d = ST_SYM_GAP;
            units_d = UNITS_SYM_GAP;
          end else begin
            state_d = ST_CHAR_GAP;
            units_d = UNITS_CHAR_GAP;
          end
        end else begin
          state_d = ST_MARK;
        end
      end

      ST_SYM_GAP: begin
        if (unit_done_s) begin
          state_d = ST_MARK;
          idx_d   = next_idx_s;
          units_d = mark_units(pat_q, next_idx_s);
          cyc_d   = 24'd0;
        end else begin
          state_d = ST_SYM_GAP;
        end
      end

      ST_CHAR_GAP, ST_WORD_GAP: begin
        if (unit_done_s) begin
          state_d = ST_IDLE;
          units_d = 3'd0;
          cyc_d   = 24'd0;
        end else begin
          state_d = state_q;
        end
      end

      default: begin
        // Unreachable encodings recover to idle
        state_d = ST_IDLE;
        units_d = 3'd0;
        cyc_d   = 24'd0;
      end
    endcase

    // Outputs are decoded from the next state so they register in step
    // with it; an empty character holds ready low for its single cycle.
    morse_d = (state_d == ST_MARK);
    if ((state_q == ST_IDLE) && xfer_s && !bus.char_space && (clen_s == 3'd0)) begin
      ready_d = 1'b0;
    end else begin
      ready_d = (state_d == ST_IDLE);
    end
    busy_d = ~ready_d;
  end

  // State, counter and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cyc_q   <= 24'd0;
      units_q <= 3'd0;
      idx_q   <= 3'd0;
      pat_q   <= 6'd0;
      morse_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      units_q <= units_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      morse_q <= morse_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.char_ready = ready_q;
  assign bus.morse_out  = morse_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_morse_sequencer.sv
// Self-checking bench for morse_sequencer with UNIT_COUNT = 4.
// Expected key-line waveforms are built from the ITU timing rules as a
// per-cycle list of levels and compared against the DUT cycle by cycle.
module tb_morse_sequencer;
  localparam int U = 4;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  bit   wave_q[$];

  morse_sequencer_if bus ();

  morse_sequencer #(.UNIT_COUNT(24'd4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the bench always ends
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // Expected per-cycle key line from the transfer edge until ready returns
  function automatic void build_wave(input bit sp, input int len, input bit [5:0] pat);
    int l;
    wave_q.delete();
    if (sp) begin
      repeat (4 * U) wave_q.push_back(1'b0);
    end else begin
      l = (len > 6) ? 6 : len;
      if (l == 0) begin
        wave_q.push_back(1'b0);
      end else begin
        for (int s = l - 1; s >= 0; s--) begin
          repeat ((pat[s] ? 3 : 1) * U) wave_q.push_back(1'b1);
          if (s != 0) repeat (U) wave_q.push_back(1'b0);
        end
        repeat (3 * U) wave_q.push_back(1'b0);
      end
    end
  endfunction

  // Wait (bounded) for ready, present a character, return #1 after transfer edge
  task automatic start_xfer(input bit sp, input logic [2:0] len, input logic [5:0] pat);
    int w;
    w = 0;
    @(negedge clk);
    while (bus.char_ready !== 1'b1 && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) begin
      checks++;
      errors++;
      $display("FAIL xfer_wait: char_ready=%b after %0d cycles, required 1", bus.char_ready, w);
    end
    bus.char_valid   = 1'b1;
    bus.char_space   = sp;
    bus.char_len     = len;
    bus.char_pattern = pat;
    @(posedge clk);
    #1;
    bus.char_valid = 1'b0;
  endtask

  // Compare the DUT against the model from #1 after the transfer edge
  task automatic run_check(input string name, input bit sp, input logic [2:0] len,
                           input logic [5:0] pat, input bit rnd, input bit preload);
    int n, bad_wave, bad_rdy, first;
    bit first_got, first_exp;
    build_wave(sp, int'(len), pat);
    n = wave_q.size();
    bad_wave = 0;
    bad_rdy = 0;
    first = -1;
    first_got = 1'b0;
    first_exp = 1'b0;
    for (int j = 0; j < n; j++) begin
      if (bus.morse_out !== wave_q[j]) begin
        if (first < 0) begin
          first = j;
          first_got = bus.morse_out;
          first_exp = wave_q[j];
        end
        bad_wave++;
      end
      if (bus.char_ready !== 1'b0 || bus.busy !== 1'b1) bad_rdy++;
      if (j == n - 1) begin
        if (preload) begin
          bus.char_valid   = 1'b1;
          bus.char_space   = 1'b0;
          bus.char_len     = 3'd1;
          bus.char_pattern = 6'd0;
        end else begin
          bus.char_valid = 1'b0;
        end
      end else if (rnd) begin
        bus.char_valid   = 1'($urandom);
        bus.char_space   = 1'($urandom);
        bus.char_len     = 3'($urandom);
        bus.char_pattern = 6'($urandom);
      end else begin
        bus.char_valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (bad_wave != 0) begin
      errors++;
      $display("FAIL wave_%s: %0d bad cycles, first at %0d got %b required %b",
               name, bad_wave, first, first_got, first_exp);
    end
    checks++;
    if (bad_rdy != 0) begin
      errors++;
      $display("FAIL busy_%s: ready/busy wrong in %0d of %0d cycles, required ready=0 busy=1",
               name, bad_rdy, n);
    end
    checks++;
    if (bus.char_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ready_return_%s: ready=%b busy=%b after %0d cycles, required ready=1 busy=0",
               name, bus.char_ready, bus.busy, n);
    end
    if (!preload) bus.char_valid = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    bus.char_valid = 1'b0;
    bus.char_space = 1'b0;
    bus.char_len = 3'd0;
    bus.char_pattern = 6'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.morse_out !== 1'b0 || bus.char_ready !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_idle: %0d bad cycles, last morse=%b ready=%b busy=%b, required 0/1/0",
               bad, bus.morse_out, bus.char_ready, bus.busy);
    end
  endtask

  task automatic test_letters();
    start_xfer(1'b0, 3'd1, 6'b000000);
    run_check("E", 1'b0, 3'd1, 6'b000000, 1'b0, 1'b0);
    start_xfer(1'b0, 3'd2, 6'b000001);
    run_check("A", 1'b0, 3'd2, 6'b000001, 1'b0, 1'b0);
    start_xfer(1'b0, 3'd5, 6'b011111);
    run_check("zero", 1'b0, 3'd5, 6'b011111, 1'b1, 1'b0);
  endtask

  task automatic test_space_len0_len7();
    start_xfer(1'b1, 3'd3, 6'b101010);
    run_check("space", 1'b1, 3'd3, 6'b101010, 1'b0, 1'b0);
    start_xfer(1'b0, 3'd0, 6'b111111);
    run_check("len0", 1'b0, 3'd0, 6'b111111, 1'b0, 1'b0);
    start_xfer(1'b0, 3'd7, 6'b111111);
    run_check("len7", 1'b0, 3'd7, 6'b111111, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    start_xfer(1'b0, 3'd1, 6'b000000);
    // Valid for the next 'E' is raised before ready returns and held
    run_check("b2b_first", 1'b0, 3'd1, 6'b000000, 1'b0, 1'b1);
    checks++;
    if (bus.morse_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_cycle: morse=%b, required 0", bus.morse_out);
    end
    @(posedge clk);
    #1;
    bus.char_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b one cycle after ready, required 1", bus.busy);
    end
    run_check("b2b_second", 1'b0, 3'd1, 6'b000000, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    start_xfer(1'b0, 3'd2, 6'b000001);
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if (bus.morse_out !== 1'b1) begin
      errors++;
      $display("FAIL areset_premark: morse=%b in second mark, required 1", bus.morse_out);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.morse_out !== 1'b0 || bus.char_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL areset_outputs: morse=%b ready=%b busy=%b, required 0/1/0",
               bus.morse_out, bus.char_ready, bus.busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start_xfer(1'b0, 3'd1, 6'b000000);
    run_check("E_after_reset", 1'b0, 3'd1, 6'b000000, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    bit sp;
    logic [2:0] len;
    logic [5:0] pat;
    for (int i = 0; i < 12; i++) begin
      sp  = ($urandom_range(0, 4) == 0);
      len = 3'($urandom_range(0, 7));
      pat = 6'($urandom);
      start_xfer(sp, len, pat);
      run_check($sformatf("rand%0d", i), sp, len, pat, 1'b1, 1'b0);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_letters();
    test_space_len0_len7();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
